microwave_timer_ctrl: RTL and testbench
=======================================

// Module: microwave_timer_ctrl
// PURPOSE
//   Cook-timer controller of the microwave. Collects keypad digits, runs the
//   min:tens:sec countdown, gates the magnetron and follows the door sensor.
//   Its registered sec/t/min digits feed decoder4x7 directly; one clk, one
//   second derived by an internal prescaler.
// PARAMETERS
//   TICKS_PER_SEC  1000  clk cycles per countdown second (1 kHz clk); >=2
//   QUICK_TENS     3     tens digit loaded by quick-start (3 -> 0:30)
// PORTS
//   clk           in   1  system clock, all logic on rising edge
//   rst           in   1  synchronous reset, active-high
//   key_valid     in   1  one-cycle strobe: key_digit holds a key
//   key_digit     in   4  BCD key value; values >9 ignored
//   start         in   1  one-cycle start/resume strobe
//   stop_clear    in   1  one-cycle stop (pause) / clear strobe
//   door_closed   in   1  level, 1 = door closed
//   sec           out  4  BCD seconds units -> decoder4x7
//   t             out  4  BCD seconds tens  -> decoder4x7
//   min           out  4  BCD minutes       -> decoder4x7
//   magnetron_on  out  1  heating enable, high only in COOKING
//   done          out  1  high while in DONE
// BEHAVIOUR
//   - All outputs registered. Reset: state IDLE, sec=t=min=0, prescaler=0,
//     magnetron_on=0, done=0. rst overrides every other input.
//   - States: IDLE, ENTRY, COOKING, PAUSED, DONE (binary-encoded).
//   - Same-cycle input priority: stop_clear > door open > start > key_valid.
//   - Key (IDLE/ENTRY, digit<=9): min<=t, t<=sec, sec<=key_digit; old min
//     is dropped; state -> ENTRY. Keys in COOKING/PAUSED/DONE ignored.
//   - start, time!=0, door_closed (IDLE/ENTRY/PAUSED): -> COOKING next cycle,
//     prescaler cleared (PAUSED: prescaler kept, resumes where it stopped).
//   - start in IDLE with time==0 and door_closed: quick-start, load
//     min=0,t=QUICK_TENS,sec=0, -> COOKING. start with door open: ignored.
//   - COOKING: prescaler counts 0..TICKS_PER_SEC-1; on the cycle it equals
//     TICKS_PER_SEC-1 it wraps to 0 and time decrements once, i.e. first
//     decrement TICKS_PER_SEC cycles after entering COOKING.
//   - Decrement: sec>0: sec-1; else sec=9 and t>0: t-1; else t=5 and min-1.
//     t values 6..9 from entry count down normally (99 s is legal).
//   - Decrement reaching 0:0:0 -> DONE in the same edge; magnetron_on=0,
//     done=1 from the next cycle.
//   - door_closed=0 in COOKING -> PAUSED next cycle, digits and prescaler
//     frozen. Door reclose alone does not resume; start required.
//   - stop_clear: COOKING -> PAUSED (hold); ENTRY/PAUSED/DONE -> IDLE with
//     digits cleared; IDLE: no effect.
//   - DONE: digits 0:0:0 held; door open also -> IDLE. start ignored.
//   - magnetron_on == (state==COOKING) registered; never high with door open
//     for more than the one detection cycle.
// TESTING (TICKS_PER_SEC=4)
//   1 keys 1,4,5 then start, door closed -> min/t/sec=1/4/5, magnetron_on=1
//     next cycle; after 4 cycles 1/4/4; after 4*105 cycles DONE, done=1.
//   2 load 1/0/0, cook 1 s -> 0/5/9 (borrow through t and min).
//   3 cooking at 0/2/7, drop door_closed -> PAUSED, digits frozen for 20
//     cycles, magnetron_on=0; reclose + start -> resumes, prescaler kept.
//   4 start with time 0 in IDLE -> 0/3/0, COOKING; stop_clear once -> PAUSED
//     digits kept; stop_clear again -> IDLE, 0/0/0.
//   5 keys 1,2,3,4 -> 2/3/4; key 12 ignored; start and key same cycle ->
//     start wins, digits unchanged.
//   6 rst asserted mid-COOKING -> next cycle IDLE, 0/0/0, magnetron_on=0.

Source files
------------

// File: rtl/microwave_timer_ctrl.sv
// Cook-timer controller: keypad digit entry, min:tens:sec countdown driven by an
// internal one-second prescaler, magnetron gating and door-interlock handling.
module microwave_timer_ctrl #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int QUICK_TENS    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] sec,
    output logic [3:0] t,
    output logic [3:0] min,
    output logic       magnetron_on,
    output logic       done
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_COOKING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int            PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_t        state, state_next;
    logic [PW-1:0] presc, presc_next;
    logic [3:0]    sec_next, t_next, min_next;
    logic [3:0]    dec_sec, dec_t, dec_min;
    logic          time_zero, dec_zero, key_ok;
    logic          magnetron_next, done_next;

    assign time_zero = (sec == 4'd0) && (t == 4'd0) && (min == 4'd0);
    assign key_ok    = key_valid && (key_digit <= 4'd9);

    // Borrow chain: seconds units wrap 0->9, tens wrap 0->5 and borrow a minute.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        dec_sec = sec - 4'd1;
        dec_t   = t;
        dec_min = min;
        if (sec == 4'd0) begin
            dec_sec = 4'd9;
            if (t != 4'd0) begin
                dec_t = t - 4'd1;
            end else begin
                dec_t   = 4'd5;
                dec_min = min - 4'd1;
            end
        end
    end

    assign dec_zero = (dec_sec == 4'd0) && (dec_t == 4'd0) && (dec_min == 4'd0);

    // Next state: stop_clear, then door open, then per-state start/key/countdown.
    always_comb begin
        state_next = state;
        presc_next = presc;
        sec_next   = sec;
        t_next     = t;
        min_next   = min;
        if (stop_clear) begin
            case (state)
                ST_COOKING: state_next = ST_PAUSED;
                ST_ENTRY, ST_PAUSED, ST_DONE: begin
                    state_next = ST_IDLE;
                    presc_next = '0;
                    sec_next   = 4'd0;
                    t_next     = 4'd0;
                    min_next   = 4'd0;
                end
                default: ;
            endcase
        end else if (!door_closed) begin
            case (state)
                ST_COOKING: state_next = ST_PAUSED;
                ST_DONE:    state_next = ST_IDLE;
                default: ;
            endcase
        end else begin
            case (state)
                ST_IDLE, ST_ENTRY: begin
                    if (start) begin
                        if (!time_zero) begin
                            state_next = ST_COOKING;
                            presc_next = '0;
                        end else if (state == ST_IDLE) begin
                            state_next = ST_COOKING;
                            presc_next = '0;
                            sec_next   = 4'd0;
                            t_next     = 4'(QUICK_TENS);
                            min_next   = 4'd0;
                        end
                    end else if (key_ok) begin
                        state_next = ST_ENTRY;
                        sec_next   = key_digit;
                        t_next     = sec;
                        min_next   = t;
                    end
                end
                ST_COOKING: begin
                    if (presc == PRESC_LAST) begin
                        presc_next = '0;
                        sec_next   = dec_sec;
                        t_next     = dec_t;
                        min_next   = dec_min;
                        if (dec_zero) state_next = ST_DONE;
                    end else begin
                        presc_next = presc + 1'b1;
                    end
                end
                ST_PAUSED: if (start) state_next = ST_COOKING;
                default: ;
            endcase
        end
    end

    always_comb begin
        magnetron_next = (state_next == ST_COOKING);
        done_next      = (state_next == ST_DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
        if (rst) begin
            state        <= ST_IDLE;
            presc        <= '0;
            sec          <= 4'd0;
            t            <= 4'd0;
            min          <= 4'd0;
            magnetron_on <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            presc        <= presc_next;
            sec          <= sec_next;
            t            <= t_next;
            min          <= min_next;
            magnetron_on <= magnetron_next;
            done         <= done_next;
        end
    end
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench for microwave_timer_ctrl: directed scenarios plus random
// keypad/door/strobe traffic checked against a seconds-arithmetic reference model.
module tb_microwave_timer_ctrl;
    localparam int TPS   = 4;
    localparam int QTENS = 3;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_COOK  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_DONE  = 4;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] t;
        logic [3:0] sec;
        logic       mag;
        logic       done;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic [3:0] sec, t, min;
    logic       magnetron_on, done;

    bit         door = 1'b1;
    int         vectors = 0;
    int         miscompares = 0;
    int         cycle = 0;
    obs_t       exp_q[$];

    // Reference model: minutes plus a 0..99 seconds field, prescaler as a cycle count.
    int         ms = M_IDLE;
    int         m_min = 0;
    int         m_ss = 0;
    int         m_pre = 0;

    microwave_timer_ctrl #(.TICKS_PER_SEC(TPS), .QUICK_TENS(QTENS)) dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .start        (start),
        .stop_clear   (stop_clear),
        .door_closed  (door_closed),
        .sec          (sec),
        .t            (t),
        .min          (min),
        .magnetron_on (magnetron_on),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit r, input bit kv, input logic [3:0] kd,
                              input bit st, input bit sc, input bit dc);
        int v;
        if (r) begin
            ms = M_IDLE; m_min = 0; m_ss = 0; m_pre = 0;
        end else if (sc) begin
            if (ms == M_COOK) ms = M_PAUSE;
            else if (ms != M_IDLE) begin
                ms = M_IDLE; m_min = 0; m_ss = 0; m_pre = 0;
            end
        end else if (!dc) begin
            if (ms == M_COOK) ms = M_PAUSE;
            else if (ms == M_DONE) ms = M_IDLE;
        end else if (ms == M_COOK) begin
            if (m_pre == TPS - 1) begin
                m_pre = 0;
                if (m_ss > 0) m_ss = m_ss - 1;
                else begin
                    m_ss  = 59;
                    m_min = m_min - 1;
                end
                if (m_min == 0 && m_ss == 0) ms = M_DONE;
            end else begin
                m_pre = m_pre + 1;
            end
        end else if (st) begin
            if ((ms == M_IDLE || ms == M_ENTRY) && (m_min * 100 + m_ss) != 0) begin
                ms = M_COOK; m_pre = 0;
            end else if (ms == M_IDLE) begin
                ms = M_COOK; m_pre = 0; m_min = 0; m_ss = QTENS * 10;
            end else if (ms == M_PAUSE) begin
                ms = M_COOK;
            end
        end else if (kv && kd <= 4'd9 && (ms == M_IDLE || ms == M_ENTRY)) begin
            v     = ((m_min * 100 + m_ss) * 10 + int'(kd)) % 1000;
            m_min = v / 100;
            m_ss  = v % 100;
            ms    = M_ENTRY;
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.min  = 4'(m_min);
        o.t    = 4'(m_ss / 10);
        o.sec  = 4'(m_ss % 10);
        o.mag  = (ms == M_COOK);
        o.done = (ms == M_DONE);
        return o;
    endfunction

    // Applies one cycle of stimulus; the expected response is queued once the edge consumes it.
    task automatic drive(input bit r, input bit kv, input logic [3:0] kd,
                         input bit st, input bit sc);
        rst         = r;
        key_valid   = kv;
        key_digit   = kd;
        start       = st;
        stop_clear  = sc;
        door_closed = door;
        model_step(r, kv, kd, st, sc, door);
        @(posedge clk);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic key(input logic [3:0] d);
        drive(1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic press_start();
        drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic press_stop();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    // Monitor: outputs are present every cycle, so one queued entry is checked per falling edge.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            cycle++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a.min  = min;
                a.t    = t;
                a.sec  = sec;
                a.mag  = magnetron_on;
                a.done = done;
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL outputs cycle %0d: got min/t/sec=%0d/%0d/%0d mag=%b done=%b, expected %0d/%0d/%0d mag=%b done=%b",
                             cycle, a.min, a.t, a.sec, a.mag, a.done,
                             e.min, e.t, e.sec, e.mag, e.done);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit         r, kv, st, sc;
        logic [3:0] kd;

        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

        // Enter 1:45, cook to completion, start ignored in DONE, door open leaves DONE.
        key(4'd1); key(4'd4); key(4'd5);
        press_start();
        idle(4 * 105 + 4);
        press_start();
        idle(2);
        door = 1'b0; idle(2);
        door = 1'b1; idle(2);

        // 1:00 borrows through tens and minutes after one second.
        key(4'd1); key(4'd0); key(4'd0);
        press_start();
        idle(6);
        press_stop(); press_stop();

        // Door opened mid-second pauses; reclose alone holds; start resumes.
        key(4'd2); key(4'd7);
        press_start();
        idle(2);
        door = 1'b0; idle(20);
        door = 1'b1; idle(3);
        press_start();
        idle(10);
        press_stop(); press_stop();

        // Quick start, pause, clear.
        press_start();
        idle(5);
        press_stop(); idle(3);
        press_stop(); idle(2);

        // Four keys drop the oldest digit, out-of-range key, start beats a key.
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        key(4'd12);
        drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        idle(3);
        press_stop(); press_stop();

        // Reset during cooking.
        key(4'd3);
        press_start();
        idle(5);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        idle(3);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if (door && $urandom_range(0, 99) < 2) door = 1'b0;
            else if (!door && $urandom_range(0, 99) < 15) door = 1'b1;
            r  = ($urandom_range(0, 999) < 2);
            kv = ($urandom_range(0, 99) < 15);
            kd = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 99) < 6);
            sc = ($urandom_range(0, 99) < 2);
            drive(r, kv, kd, st, sc);
        end

        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
